biriscv_v_issue_ctrl: RTL and testbench

- Scheduler in front of the single-cycle vector ALU (VADD/VSUB/VRSUB/VMINU/VMAXU, .vv/.vx/.vi).
- Accepts vector ALU ops from the two in-order issue pipes, checks vector RAW/WAW hazards with a per-register scoreboard, and reads the VRF.
- Drives the ALU from a registered EX stage and writes results back through a WB register with VRF backpressure.
- Sits between the biRISC-V dual-issue stage and the vector register file.

---
 rtl/biriscv_v_issue_ctrl_pkg.sv | 15 +
 rtl/biriscv_v_scoreboard.sv | 42 ++++
 rtl/biriscv_v_issue_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_biriscv_v_issue_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biriscv_v_issue_ctrl_pkg.sv
// Shared definitions for the vector ALU issue controller: field widths,
// the vm bit position and a small decode helper.
package biriscv_v_issue_ctrl_pkg;

  localparam int VREG_IDX_W = 5;
  localparam int VM_BIT     = 25;

  typedef logic [VREG_IDX_W-1:0] vreg_idx_t;

  // vm=0 means the op is masked by v0, so v0 becomes an extra source.
  function automatic logic uses_v0(input logic [31:0] insn);
    return ~insn[VM_BIT];
  endfunction

endpackage

// File: rtl/biriscv_v_scoreboard.sv
// Per-register pending-write scoreboard: one set port, two clear ports,
// and a four-source hazard query (va, vb, vd, optional v0).
module biriscv_v_scoreboard
  import biriscv_v_issue_ctrl_pkg::*;
#(
  parameter int NUM_VREGS = 32
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_set_valid,
  input  vreg_idx_t i_set_idx,
  input  logic      i_clr_wb_valid,
  input  vreg_idx_t i_clr_wb_idx,
  input  logic      i_clr_ex_valid,
  input  vreg_idx_t i_clr_ex_idx,
  input  vreg_idx_t i_qry_va,
  input  vreg_idx_t i_qry_vb,
  input  vreg_idx_t i_qry_vd,
  input  logic      i_qry_v0,
  output logic      o_hazard
);

  logic [NUM_VREGS-1:0] r_pending;
  logic [NUM_VREGS-1:0] w_pending_next;

  // Set is applied last so a same-index set/clear in one cycle leaves the bit set.
  always_comb begin
    w_pending_next = r_pending;
    if (i_clr_wb_valid) w_pending_next[i_clr_wb_idx] = 1'b0;
    if (i_clr_ex_valid) w_pending_next[i_clr_ex_idx] = 1'b0;
    if (i_set_valid)    w_pending_next[i_set_idx]    = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pending <= '0;
    else          r_pending <= w_pending_next;
  end

  assign o_hazard = r_pending[i_qry_va] | r_pending[i_qry_vb] |
                    r_pending[i_qry_vd] | (i_qry_v0 & r_pending[0]);

endmodule

// File: rtl/biriscv_v_issue_ctrl.sv
// Vector ALU issue controller: picks the oldest offered op, checks it against
// the scoreboard, reads the VRF, and runs it through registered EX and WB stages.
module biriscv_v_issue_ctrl
  import biriscv_v_issue_ctrl_pkg::*;
#(
  parameter int VLEN      = 128,
  parameter int ELEN      = 32,
  parameter int NUM_VREGS = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            p0_valid_i,
  input  logic [31:0]     p0_opcode_i,
  input  logic [4:0]      p0_vd_i,
  input  logic [4:0]      p0_va_i,
  input  logic [4:0]      p0_vb_i,
  input  logic [31:0]     p0_ra_operand_i,
  output logic            p0_accept_o,
  input  logic            p1_valid_i,
  input  logic [31:0]     p1_opcode_i,
  input  logic [4:0]      p1_vd_i,
  input  logic [4:0]      p1_va_i,
  input  logic [4:0]      p1_vb_i,
  input  logic [31:0]     p1_ra_operand_i,
  output logic            p1_accept_o,
  input  logic            flush_i,
  output logic [4:0]      vrf_rd_a_idx_o,
  output logic [4:0]      vrf_rd_b_idx_o,
  input  logic [VLEN-1:0] vrf_rd_a_i,
  input  logic [VLEN-1:0] vrf_rd_b_i,
  input  logic [VLEN-1:0] vrf_v0_i,
  output logic [31:0]     alu_opcode_o,
  output logic [31:0]     alu_ra_operand_o,
  output logic [VLEN-1:0] alu_va_o,
  output logic [VLEN-1:0] alu_vb_o,
  output logic [VLEN-1:0] alu_vmask_o,
  input  logic [VLEN-1:0] alu_result_i,
  output logic            vrf_wr_valid_o,
  output logic [4:0]      vrf_wr_idx_o,
  output logic [VLEN-1:0] vrf_wr_data_o,
  input  logic            vrf_wr_ready_i,
  output logic            busy_o,
  output logic [31:0]     perf_issue_o,
  output logic [31:0]     perf_stall_o
);

  // Handshakes: an op moves from pipe N when pN_valid_i & pN_accept_o (accept is
  // combinational on valid); a write moves when vrf_wr_valid_o & vrf_wr_ready_i,
  // with valid/idx/data held stable until then.

  // ELEN only rides along to the ALU; element lanes must tile the register.
  if ((VLEN % ELEN) != 0) begin : g_elen_not_tiling
  end

  logic        w_sel_p1;
  logic        w_cand_valid;
  logic [31:0] w_cand_opcode;
  logic [31:0] w_cand_ra;
  vreg_idx_t   w_cand_vd;
  vreg_idx_t   w_cand_va;
  vreg_idx_t   w_cand_vb;
  logic        w_hazard;
  logic        w_stage_busy;
  logic        w_accept;
  logic        w_wb_fire;
  logic        w_ex_adv;
  logic        w_ex_flush;

  logic            r_ex_valid;
  vreg_idx_t       r_ex_vd;
  logic [31:0]     r_ex_opcode;
  logic [31:0]     r_ex_ra;
  logic [VLEN-1:0] r_ex_va;
  logic [VLEN-1:0] r_ex_vb;
  logic [VLEN-1:0] r_ex_vmask;

  logic            r_wb_valid;
  vreg_idx_t       r_wb_idx;
  logic [VLEN-1:0] r_wb_data;

  logic [31:0] r_perf_issue;
  logic [31:0] r_perf_stall;

  // Pipe 0 is older; pipe 1 is only considered when pipe 0 offers nothing.
  always_comb begin
    w_sel_p1      = ~p0_valid_i;
    w_cand_valid  = p0_valid_i | p1_valid_i;
    w_cand_opcode = p0_opcode_i;
    w_cand_ra     = p0_ra_operand_i;
    w_cand_vd     = p0_vd_i;
    w_cand_va     = p0_va_i;
    w_cand_vb     = p0_vb_i;
    if (w_sel_p1) begin
      w_cand_opcode = p1_opcode_i;
      w_cand_ra     = p1_ra_operand_i;
      w_cand_vd     = p1_vd_i;
      w_cand_va     = p1_va_i;
      w_cand_vb     = p1_vb_i;
    end
  end

  biriscv_v_scoreboard #(
    .NUM_VREGS(NUM_VREGS)
  ) u_scoreboard (
    .i_clk          (clk_i),
    .i_rst_n        (rst_ni),
    .i_set_valid    (w_accept),
    .i_set_idx      (w_cand_vd),
    .i_clr_wb_valid (w_wb_fire),
    .i_clr_wb_idx   (r_wb_idx),
    .i_clr_ex_valid (w_ex_flush),
    .i_clr_ex_idx   (r_ex_vd),
    .i_qry_va       (w_cand_va),
    .i_qry_vb       (w_cand_vb),
    .i_qry_vd       (w_cand_vd),
    .i_qry_v0       (uses_v0(w_cand_opcode)),
    .o_hazard       (w_hazard)
  );

  assign w_wb_fire    = r_wb_valid & vrf_wr_ready_i;
  assign w_stage_busy = r_ex_valid & r_wb_valid & ~vrf_wr_ready_i;
  assign w_ex_flush   = flush_i & r_ex_valid;
  assign w_ex_adv     = r_ex_valid & ~flush_i & (~r_wb_valid | vrf_wr_ready_i);
  // rst_ni gates accept so nothing is reported as taken while reset is held.
  assign w_accept     = rst_ni & w_cand_valid & ~w_hazard & ~w_stage_busy & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ex_valid  <= 1'b0;
      r_ex_vd     <= '0;
      r_ex_opcode <= '0;
      r_ex_ra     <= '0;
      r_ex_va     <= '0;
      r_ex_vb     <= '0;
      r_ex_vmask  <= '0;
    end else if (w_accept) begin
      r_ex_valid  <= 1'b1;
      r_ex_vd     <= w_cand_vd;
      r_ex_opcode <= w_cand_opcode;
      r_ex_ra     <= w_cand_ra;
      r_ex_va     <= vrf_rd_a_i;
      r_ex_vb     <= vrf_rd_b_i;
      r_ex_vmask  <= vrf_v0_i;
    end else if (flush_i | w_ex_adv) begin
      r_ex_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb_valid <= 1'b0;
      r_wb_idx   <= '0;
      r_wb_data  <= '0;
    end else if (w_ex_adv) begin
      r_wb_valid <= 1'b1;
      r_wb_idx   <= r_ex_vd;
      r_wb_data  <= alu_result_i;
    end else if (w_wb_fire) begin
      r_wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_issue <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_accept)                  r_perf_issue <= r_perf_issue + 32'd1;
      if (w_cand_valid && !w_accept) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign p0_accept_o      = w_accept & ~w_sel_p1;
  assign p1_accept_o      = w_accept & w_sel_p1;
  assign vrf_rd_a_idx_o   = w_cand_va;
  assign vrf_rd_b_idx_o   = w_cand_vb;
  assign alu_opcode_o     = r_ex_opcode;
  assign alu_ra_operand_o = r_ex_ra;
  assign alu_va_o         = r_ex_va;
  assign alu_vb_o         = r_ex_vb;
  assign alu_vmask_o      = r_ex_vmask;
  assign vrf_wr_valid_o   = r_wb_valid;
  assign vrf_wr_idx_o     = r_wb_idx;
  assign vrf_wr_data_o    = r_wb_data;
  assign busy_o           = r_ex_valid | r_wb_valid;
  assign perf_issue_o     = r_perf_issue;
  assign perf_stall_o     = r_perf_stall;

endmodule

// File: tb/tb_biriscv_v_issue_ctrl.sv
// Directed bench for biriscv_v_issue_ctrl: small VRF/ALU models, an expected
// write queue, a table of accept decisions and hand-written pipeline sequences.
module tb_biriscv_v_issue_ctrl;

  localparam int VLEN = 128;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            p0_valid, p1_valid;
  logic [31:0]     p0_opcode, p1_opcode, p0_ra, p1_ra;
  logic [4:0]      p0_vd, p0_va, p0_vb, p1_vd, p1_va, p1_vb;
  logic            p0_accept_o, p1_accept_o;
  logic            flush;
  logic [4:0]      vrf_rd_a_idx_o, vrf_rd_b_idx_o;
  logic [VLEN-1:0] vrf_rd_a, vrf_rd_b, vrf_v0;
  logic [31:0]     alu_opcode_o, alu_ra_operand_o;
  logic [VLEN-1:0] alu_va_o, alu_vb_o, alu_vmask_o, alu_result;
  logic            vrf_wr_valid_o;
  logic [4:0]      vrf_wr_idx_o;
  logic [VLEN-1:0] vrf_wr_data_o;
  logic            wr_ready;
  logic            busy_o;
  logic [31:0]     perf_issue_o, perf_stall_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [VLEN+4:0] exp_q[$];

  always #5 clk = ~clk;

  biriscv_v_issue_ctrl #(.VLEN(VLEN), .ELEN(32), .NUM_VREGS(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .p0_valid_i(p0_valid), .p0_opcode_i(p0_opcode), .p0_vd_i(p0_vd),
    .p0_va_i(p0_va), .p0_vb_i(p0_vb), .p0_ra_operand_i(p0_ra), .p0_accept_o(p0_accept_o),
    .p1_valid_i(p1_valid), .p1_opcode_i(p1_opcode), .p1_vd_i(p1_vd),
    .p1_va_i(p1_va), .p1_vb_i(p1_vb), .p1_ra_operand_i(p1_ra), .p1_accept_o(p1_accept_o),
    .flush_i(flush),
    .vrf_rd_a_idx_o(vrf_rd_a_idx_o), .vrf_rd_b_idx_o(vrf_rd_b_idx_o),
    .vrf_rd_a_i(vrf_rd_a), .vrf_rd_b_i(vrf_rd_b), .vrf_v0_i(vrf_v0),
    .alu_opcode_o(alu_opcode_o), .alu_ra_operand_o(alu_ra_operand_o),
    .alu_va_o(alu_va_o), .alu_vb_o(alu_vb_o), .alu_vmask_o(alu_vmask_o),
    .alu_result_i(alu_result),
    .vrf_wr_valid_o(vrf_wr_valid_o), .vrf_wr_idx_o(vrf_wr_idx_o),
    .vrf_wr_data_o(vrf_wr_data_o), .vrf_wr_ready_i(wr_ready),
    .busy_o(busy_o), .perf_issue_o(perf_issue_o), .perf_stall_o(perf_stall_o)
  );

  // Register contents are a recognisable function of the index.
  function automatic logic [VLEN-1:0] pa(input logic [4:0] i);
    return {4{32'hA000_0000 | {27'd0, i}}};
  endfunction
  function automatic logic [VLEN-1:0] pb(input logic [4:0] i);
    return {4{32'h0B00_0000 | {27'd0, i}}};
  endfunction
  function automatic logic [31:0] vop(input logic [5:0] f6, input logic vm,
                                      input logic [4:0] vs2, input logic [4:0] vs1,
                                      input logic [4:0] vd);
    return {f6, vm, vs2, vs1, 3'b000, vd, 7'b1010111};
  endfunction

  localparam logic [VLEN-1:0] V0_PAT = {4{32'h5A5A_0F0F}};

  always_comb vrf_rd_a = pa(vrf_rd_a_idx_o);
  always_comb vrf_rd_b = pb(vrf_rd_b_idx_o);
  assign vrf_v0     = V0_PAT;
  assign alu_result = alu_va_o + alu_vb_o;

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Write scoreboard: every completed VRF write must match the queue head.
  always @(negedge clk) begin
    if (rst_n && vrf_wr_valid_o && wr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr_unexpected actual_idx=%0d required=none @%0t", vrf_wr_idx_o, $time);
      end else begin
        chk("wr_beat", {vrf_wr_idx_o, vrf_wr_data_o}, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [4:0] vd, input logic [4:0] va,
                        input logic [4:0] vb, input logic vm);
    p0_valid = v; p0_vd = vd; p0_va = va; p0_vb = vb;
    p0_opcode = vop(6'b000000, vm, va, vb, vd);
    p0_ra = 32'hCAFE_0000 | {27'd0, vd};
  endtask

  task automatic drive1(input logic v, input logic [4:0] vd, input logic [4:0] va,
                        input logic [4:0] vb, input logic vm);
    p1_valid = v; p1_vd = vd; p1_va = va; p1_vb = vb;
    p1_opcode = vop(6'b000010, vm, va, vb, vd);
    p1_ra = 32'hBEEF_0000 | {27'd0, vd};
  endtask

  task automatic idle();
    drive0(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    drive1(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    flush = 1'b0;
  endtask

  task automatic expect_wr(input logic [4:0] vd, input logic [4:0] va, input logic [4:0] vb);
    exp_q.push_back({vd, pa(va) + pb(vb)});
  endtask

  task automatic drain();
    int k;
    idle();
    k = 0;
    while (busy_o && k < 20) begin
      step();
      k++;
    end
    chk("drain_idle", busy_o, 1'b0);
  endtask

  typedef struct {
    logic       p0_v;
    logic [4:0] p0_vd, p0_va, p0_vb;
    logic       p0_vm;
    logic       p1_v;
    logic [4:0] p1_vd, p1_va, p1_vb;
    logic       p1_vm;
    logic       rdy, fl;
    logic       e_a0, e_a1;
    logic [4:0] e_rda;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Accept decisions with WB holding vd=5 and EX holding vd=0 (both pending).
    vecs[0]  = '{1, 1, 2, 3, 1,  0, 0, 0, 0, 1,  1, 0,  1, 0, 2};
    vecs[1]  = '{1, 1, 5, 3, 1,  0, 0, 0, 0, 1,  1, 0,  0, 0, 5};
    vecs[2]  = '{1, 1, 2, 5, 1,  0, 0, 0, 0, 1,  1, 0,  0, 0, 2};
    vecs[3]  = '{1, 5, 2, 3, 1,  0, 0, 0, 0, 1,  1, 0,  0, 0, 2};
    vecs[4]  = '{1, 1, 2, 3, 0,  0, 0, 0, 0, 1,  1, 0,  0, 0, 2};
    vecs[5]  = '{1, 1, 0, 3, 1,  0, 0, 0, 0, 1,  1, 0,  0, 0, 0};
    vecs[6]  = '{0, 1, 9, 3, 1,  1, 1, 2, 3, 1,  1, 0,  0, 1, 2};
    vecs[7]  = '{1, 1, 5, 3, 1,  1, 2, 6, 7, 1,  1, 0,  0, 0, 5};
    vecs[8]  = '{1, 1, 2, 3, 1,  1, 2, 6, 7, 1,  1, 0,  1, 0, 2};
    vecs[9]  = '{1, 1, 2, 3, 1,  0, 0, 0, 0, 1,  0, 0,  0, 0, 2};
    vecs[10] = '{1, 1, 2, 3, 1,  0, 0, 0, 0, 1,  1, 1,  0, 0, 2};
    vecs[11] = '{0, 1, 9, 3, 1,  0, 2, 6, 7, 1,  1, 0,  0, 0, 6};
    vecs[12] = '{0, 1, 9, 3, 1,  1, 5, 2, 3, 1,  1, 0,  0, 0, 2};
    vecs[13] = '{0, 1, 9, 3, 1,  1, 1, 2, 3, 0,  1, 0,  0, 0, 2};

    // Reset state, with an op offered during reset.
    rst_n = 1'b0;
    wr_ready = 1'b1;
    idle();
    drive0(1'b1, 5'd3, 5'd1, 5'd2, 1'b1);
    #12;
    chk("rst_p0_accept", p0_accept_o, 1'b0);
    chk("rst_wr_valid", vrf_wr_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_perf_issue", perf_issue_o, 32'd0);
    chk("rst_perf_stall", perf_stall_o, 32'd0);
    chk("rst_alu_va", alu_va_o, '0);
    step();
    rst_n = 1'b1;
    idle();
    step();

    // Single op vd=3 <- v1 + v2, then a consumer of v3 three cycles later.
    drive0(1'b1, 5'd3, 5'd1, 5'd2, 1'b1);
    #1;
    chk("t1_accept", p0_accept_o, 1'b1);
    chk("t1_rd_a_idx", vrf_rd_a_idx_o, 5'd1);
    chk("t1_rd_b_idx", vrf_rd_b_idx_o, 5'd2);
    expect_wr(5'd3, 5'd1, 5'd2);
    step();
    idle();
    chk("t1_alu_va", alu_va_o, pa(5'd1));
    chk("t1_alu_vb", alu_vb_o, pb(5'd2));
    chk("t1_alu_vmask", alu_vmask_o, V0_PAT);
    chk("t1_alu_opcode", alu_opcode_o, vop(6'b000000, 1'b1, 5'd1, 5'd2, 5'd3));
    chk("t1_alu_ra", alu_ra_operand_o, 32'hCAFE_0003);
    chk("t1_c1_wr_valid", vrf_wr_valid_o, 1'b0);
    chk("t1_c1_busy", busy_o, 1'b1);
    step();
    chk("t1_c2_wr_valid", vrf_wr_valid_o, 1'b1);
    chk("t1_c2_wr_idx", vrf_wr_idx_o, 5'd3);
    chk("t1_c2_wr_data", vrf_wr_data_o, pa(5'd1) + pb(5'd2));
    step();
    drive0(1'b1, 5'd4, 5'd3, 5'd1, 1'b1);
    #1;
    chk("t1_c3_consumer_accept", p0_accept_o, 1'b1);
    expect_wr(5'd4, 5'd3, 5'd1);
    step();
    drain();
    chk("t1_perf_issue", perf_issue_o, 32'd2);
    chk("t1_perf_stall", perf_stall_o, 32'd0);

    // RAW: producer vd=5 at cycle 0, consumer va=5 offered from cycle 1.
    drive0(1'b1, 5'd5, 5'd1, 5'd2, 1'b1);
    #1;
    chk("raw_c0_accept", p0_accept_o, 1'b1);
    expect_wr(5'd5, 5'd1, 5'd2);
    for (int c = 1; c <= 3; c++) begin
      step();
      drive0(1'b1, 5'd6, 5'd5, 5'd2, 1'b1);
      #1;
      chk($sformatf("raw_c%0d_accept", c), p0_accept_o, (c == 3));
    end
    expect_wr(5'd6, 5'd5, 5'd2);
    step();
    drain();
    chk("raw_perf_issue", perf_issue_o, 32'd4);
    chk("raw_perf_stall", perf_stall_o, 32'd2);

    // Ordering: blocked p0 keeps a clean p1 waiting.
    drive0(1'b1, 5'd5, 5'd1, 5'd2, 1'b1);
    #1;
    chk("ord_c0_accept", p0_accept_o, 1'b1);
    expect_wr(5'd5, 5'd1, 5'd2);
    for (int c = 1; c <= 3; c++) begin
      step();
      drive0(1'b1, 5'd7, 5'd1, 5'd5, 1'b1);
      drive1(1'b1, 5'd8, 5'd2, 5'd3, 1'b1);
      #1;
      chk($sformatf("ord_c%0d_p0", c), p0_accept_o, (c == 3));
      chk($sformatf("ord_c%0d_p1", c), p1_accept_o, 1'b0);
    end
    expect_wr(5'd7, 5'd1, 5'd5);
    step();
    drive0(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    chk("ord_c4_p1", p1_accept_o, 1'b1);
    expect_wr(5'd8, 5'd2, 5'd3);
    step();
    drain();
    chk("ord_perf_issue", perf_issue_o, 32'd7);
    chk("ord_perf_stall", perf_stall_o, 32'd4);

    // Backpressure: park A(vd=5) in WB and B(vd=0) in EX, then run the table.
    drive0(1'b1, 5'd5, 5'd1, 5'd2, 1'b1);
    #1;
    chk("bp_a_accept", p0_accept_o, 1'b1);
    expect_wr(5'd5, 5'd1, 5'd2);
    step();
    wr_ready = 1'b0;
    drive0(1'b1, 5'd0, 5'd3, 5'd4, 1'b1);
    #1;
    chk("bp_b_accept", p0_accept_o, 1'b1);
    expect_wr(5'd0, 5'd3, 5'd4);
    step();
    idle();
    for (int i = 0; i < 14; i++) begin
      drive0(vecs[i].p0_v, vecs[i].p0_vd, vecs[i].p0_va, vecs[i].p0_vb, vecs[i].p0_vm);
      drive1(vecs[i].p1_v, vecs[i].p1_vd, vecs[i].p1_va, vecs[i].p1_vb, vecs[i].p1_vm);
      wr_ready = vecs[i].rdy;
      flush = vecs[i].fl;
      #2;
      chk($sformatf("vec%0d_p0_accept", i), p0_accept_o, vecs[i].e_a0);
      chk($sformatf("vec%0d_p1_accept", i), p1_accept_o, vecs[i].e_a1);
      chk($sformatf("vec%0d_rd_a_idx", i), vrf_rd_a_idx_o, vecs[i].e_rda);
      chk($sformatf("vec%0d_wb_idx_hold", i), vrf_wr_idx_o, 5'd5);
      chk($sformatf("vec%0d_wb_data_hold", i), vrf_wr_data_o, pa(5'd1) + pb(5'd2));
      chk($sformatf("vec%0d_ex_hold", i), alu_va_o, pa(5'd3));
      #1;
      idle();
      wr_ready = 1'b0;
      step();
    end
    wr_ready = 1'b1;
    #1;
    chk("bp_rel0_idx", vrf_wr_idx_o, 5'd5);
    step();
    chk("bp_rel1_valid", vrf_wr_valid_o, 1'b1);
    chk("bp_rel1_idx", vrf_wr_idx_o, 5'd0);
    step();
    chk("bp_rel2_valid", vrf_wr_valid_o, 1'b0);
    chk("bp_rel2_busy", busy_o, 1'b0);
    drain();

    // Flush: Y(vd=7) flushed in EX while X(vd=6) in WB still completes.
    drive0(1'b1, 5'd6, 5'd1, 5'd2, 1'b1);
    #1;
    chk("fl_x_accept", p0_accept_o, 1'b1);
    expect_wr(5'd6, 5'd1, 5'd2);
    step();
    drive0(1'b1, 5'd7, 5'd2, 5'd3, 1'b1);
    #1;
    chk("fl_y_accept", p0_accept_o, 1'b1);
    step();
    flush = 1'b1;
    drive0(1'b1, 5'd9, 5'd1, 5'd2, 1'b1);
    #1;
    chk("fl_blocks_accept", p0_accept_o, 1'b0);
    chk("fl_wb_valid", vrf_wr_valid_o, 1'b1);
    chk("fl_wb_idx", vrf_wr_idx_o, 5'd6);
    step();
    flush = 1'b0;
    drive0(1'b1, 5'd9, 5'd7, 5'd2, 1'b1);
    #1;
    chk("fl_v7_released", p0_accept_o, 1'b1);
    chk("fl_no_write7", vrf_wr_valid_o, 1'b0);
    chk("fl_busy_empty", busy_o, 1'b0);
    expect_wr(5'd9, 5'd7, 5'd2);
    step();
    drain();

    // Masked op (vm=0) waits for the pending v0 write.
    drive0(1'b1, 5'd0, 5'd1, 5'd2, 1'b1);
    #1;
    chk("mask_v0_accept", p0_accept_o, 1'b1);
    expect_wr(5'd0, 5'd1, 5'd2);
    for (int c = 1; c <= 3; c++) begin
      step();
      drive0(1'b1, 5'd10, 5'd11, 5'd12, 1'b0);
      #1;
      chk($sformatf("mask_c%0d_accept", c), p0_accept_o, (c == 3));
    end
    expect_wr(5'd10, 5'd11, 5'd12);
    step();
    drain();
    chk("mask_perf_issue", perf_issue_o, 32'd14);
    chk("mask_perf_stall", perf_stall_o, 32'd7);

    // Reset while an op sits in WB.
    drive0(1'b1, 5'd3, 5'd1, 5'd2, 1'b1);
    #1;
    chk("rmid_accept", p0_accept_o, 1'b1);
    step();
    idle();
    wr_ready = 1'b0;
    step();
    chk("rmid_wb_valid", vrf_wr_valid_o, 1'b1);
    drive0(1'b1, 5'd4, 5'd1, 5'd2, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rmid_wr_valid", vrf_wr_valid_o, 1'b0);
    chk("rmid_busy", busy_o, 1'b0);
    chk("rmid_perf_issue", perf_issue_o, 32'd0);
    chk("rmid_perf_stall", perf_stall_o, 32'd0);
    chk("rmid_accept_low", p0_accept_o, 1'b0);
    chk("rmid_wr_data", vrf_wr_data_o, '0);
    step();
    rst_n = 1'b1;
    idle();
    wr_ready = 1'b1;
    step();
    drive0(1'b1, 5'd2, 5'd1, 5'd3, 1'b1);
    #1;
    chk("post_rst_accept", p0_accept_o, 1'b1);
    expect_wr(5'd2, 5'd1, 5'd3);
    step();
    drain();
    chk("post_rst_perf_issue", perf_issue_o, 32'd1);
    chk("post_rst_perf_stall", perf_stall_o, 32'd0);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
